// File: rtl/moore_machine_pkg.sv
// Shared encodings for the two-consecutive-ones Moore detector.
package moore_machine_pkg;
  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S0 = 2'b00;
  localparam state_t S1 = 2'b01;
  localparam state_t S2 = 2'b10;
  localparam state_t S3 = 2'b11;
endpackage

// File: rtl/moore_machine.sv
// Serial Moore detector: detect is high while the last two sampled bits are 1,1.
// o_state exposes the state register for observation and checker binding.
module moore_machine
  import moore_machine_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               inbits,
  output logic               detect,
  output logic [STATE_W-1:0] o_state
);

  state_t r_state;
  state_t w_next;

  always_comb begin
    w_next = S0;
    case (r_state)
      S0:      w_next = inbits ? S1 : S0;
      S1:      w_next = inbits ? S3 : S2;
      S2:      w_next = inbits ? S1 : S0;
      S3:      w_next = inbits ? S3 : S2;
      default: w_next = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S0;
    else       r_state <= w_next;
  end

  // Output comes from the state register only, never from inbits.
  assign detect  = (r_state == S3);
  assign o_state = r_state;

endmodule

// File: tb/tb_moore_machine.sv
// Directed-vector bench for moore_machine with a queue-based scoreboard.
module tb_moore_machine;
  localparam int W = 3;

  logic       clk;
  logic       reset;
  logic       inbits;
  logic       detect;
  logic [1:0] o_state;

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_errors;

  moore_machine dut (
    .clk     (clk),
    .reset   (reset),
    .inbits  (inbits),
    .detect  (detect),
    .o_state (o_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset  = 1'b1;
    inbits = 1'b0;
  end

  // driver: set inputs before the next rising edge and log what must follow it
  task automatic step(input logic r, input logic b, input logic [1:0] st, input logic d);
    @(negedge clk);
    reset  = r;
    inbits = b;
    exp_q.push_back({st, d});
  endtask

  // monitor / scoreboard: one expected entry per driven edge
  initial begin
    n_checks = 0;
    n_errors = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [W-1:0] exp_v;
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({o_state, detect} !== exp_v) begin
          n_errors++;
          $display("FAIL check%0d state/detect: got state=%b detect=%b, expected state=%b detect=%b",
                   n_checks, o_state, detect, exp_v[2:1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    // reset held over several edges, regardless of inbits
    step(1, 0, 2'b00, 0);
    step(1, 0, 2'b00, 0);
    step(1, 1, 2'b00, 0);
    // 1,0,1,1,0
    step(0, 1, 2'b01, 0);
    step(0, 0, 2'b10, 0);
    step(0, 1, 2'b01, 0);
    step(0, 1, 2'b11, 1);
    step(0, 0, 2'b10, 0);
    // run of four 1s
    step(1, 0, 2'b00, 0);
    step(0, 1, 2'b01, 0);
    step(0, 1, 2'b11, 1);
    step(0, 1, 2'b11, 1);
    step(0, 1, 2'b11, 1);
    // reset while in S3 with inbits=1, then 1,1
    step(1, 1, 2'b00, 0);
    step(0, 1, 2'b01, 0);
    step(0, 1, 2'b11, 1);
    // 1,1,0,1 then a further 1
    step(1, 0, 2'b00, 0);
    step(0, 1, 2'b01, 0);
    step(0, 1, 2'b11, 1);
    step(0, 0, 2'b10, 0);
    step(0, 1, 2'b01, 0);
    step(0, 1, 2'b11, 1);
    // 0,0,0 then 1,0,0
    step(1, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0);
    step(0, 1, 2'b01, 0);
    step(0, 0, 2'b10, 0);
    step(0, 0, 2'b00, 0);

    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
